tjrpu_wb_arbiter: RTL and testbench
===================================

# tjrpu_wb_arbiter

Two-master, one-slave Wishbone arbiter in front of the tjrpu internal register/memory bus. Master 0 is the management SoC Wishbone slave port (wbs_*); master 1 is the tjrpu debug/DMA master. It grants the single downstream bus round-robin, holds a grant for a whole cycle (cyc) so block transfers are not split, and terminates hung slave accesses with a timeout. Timeouts are reported on an interrupt line intended for user_irq.

## Interface
- TIMEOUT, 255: cycles without s_ack_i, while granted stb is high, before forced termination (1..255).
- ERR_DATA, 32'hDEAD_BEEF: read data returned on a timed-out access.

- wb_clk_i  in  1  sole clock; all state on rising edge.
- wb_rst_i  in  1  reset; asynchronous and active-high.
- m0_cyc_i, m0_stb_i, m0_we_i  in  1 each  master 0 Wishbone controls.
- m0_sel_i  in  4  master 0 byte selects.
- m0_adr_i, m0_dat_i  in  32 each  master 0 address and write data.
- m0_ack_o  out  1  master 0 acknowledge.
- m0_dat_o  out  32  master 0 read data.
- m1_*  same set as m0_*  master 1.
- s_cyc_o, s_stb_o, s_we_o  out  1 each  downstream controls.
- s_sel_o  out  4  downstream byte selects.
- s_adr_o, s_dat_o  out  32 each  downstream address and write data.
- s_ack_i  in  1  downstream acknowledge.
- s_dat_i  in  32  downstream read data.
- timeout_irq_o  out  1  one-cycle pulse per timeout.
- timeout_cnt_o  out  8  saturating count of timeouts since reset.

## Operation
- States: IDLE, GNT0, GNT1. Registered `last` (which master was last granted) resets to 1, so master 0 wins the first contention.
- Request: reqN = mN_cyc_i & mN_stb_i.
- Arbitration, from IDLE or on release:
  - Only one master requests: grant it.
  - Both request: grant the master that is not `last`.
  - `last` updates when a grant is taken.
- In GNTn:
  - s_cyc_o, s_stb_o, s_we_o, s_sel_o, s_adr_o and s_dat_o follow master n combinationally.
  - mn_ack_o = s_ack_i & mn_stb_i.
  - mn_dat_o = s_dat_i.
  - The non-granted master sees ack 0 and dat 0.
- In IDLE: all s_* outputs are 0.
- Release: when the granted master's cyc_i is sampled low.
  - Next state comes from the arbitration rule above.
  - If the other master is requesting, the switch goes directly GNT0 to GNT1 (or the reverse) with no IDLE cycle.
  - Otherwise next state is IDLE.
- Grant is held while the granted cyc_i stays high, even if stb drops between beats and the other master is requesting.
- Timeout counter (8 bits):
  - Increments each cycle in GNTn with mn_stb_i=1 and s_ack_i=0.
  - Clears on s_ack_i, on stb low, and on any state change.
- Timeout event, when the counter equals TIMEOUT:
  - That cycle, mn_ack_o=1, mn_dat_o=ERR_DATA, s_cyc_o=0 and s_stb_o=0.
  - timeout_irq_o pulses high the next cycle.
  - timeout_cnt_o increments and saturates at 255.
  - Counter clears; the grant is kept until master n drops cyc.
- Slave ack in the same cycle the counter reaches TIMEOUT: the slave ack wins. s_dat_i is returned, no timeout is counted, no irq.
- Master drops cyc mid-access without an ack: the downstream access is abandoned. s_cyc_o goes low combinationally in that cycle, and the state is released next edge.

## Timing
- Reset values: state IDLE, last=1, counter 0, timeout_cnt_o 0, timeout_irq_o 0, all s_* outputs 0, all m*_ack_o and m*_dat_o 0.
- Reset asserted mid-transfer: everything returns to reset values immediately; no ack is issued.
- Grant latency: a request sampled in IDLE at edge k drives s_cyc_o/s_stb_o from edge k onward, i.e. visible in cycle k+1.
- Data and ack path through a granted master: 0 cycles, purely combinational.
- Switch latency: cyc low sampled at edge k, so the other master is granted during cycle k+1.
- Timeout: a slave that never acks gives mn_ack_o in the (TIMEOUT+1)-th cycle of stb high, counting the first stb cycle as cycle 1. timeout_irq_o is high in the following cycle only.

## Test plan
- Single master 0 read:
  - Stimulus: m0 read at 0x3000_0004, slave acks after 2 cycles with 0x1234_5678.
  - Required: m0_dat_o=0x1234_5678 with m0_ack_o; m1_ack_o stays 0; state returns to IDLE one cycle after cyc drops.
- Contention after reset:
  - Stimulus: m0 and m1 both request in the same cycle.
  - Required: m0 granted first. m1 granted in the cycle immediately after m0 drops cyc, with no IDLE cycle. A repeat of the simultaneous request then grants m1 first.
- Burst hold:
  - Stimulus: m1 performs 4 back-to-back acked writes under one cyc while m0 requests throughout.
  - Required: s_adr_o shows all 4 m1 addresses; m0 is granted only after m1's cyc drops.
- Timeout:
  - Stimulus: TIMEOUT=8, slave never acks a m0 read.
  - Required: m0_ack_o in the 9th stb cycle with 0xDEAD_BEEF; s_stb_o=0 that cycle; timeout_irq_o high one cycle later; timeout_cnt_o=1. With ack instead arriving in the 9th cycle: no timeout, count stays 0.
- Abort and reset:
  - Stimulus: m0 drops cyc mid-wait.
  - Required: s_cyc_o goes low the same cycle.
  - Stimulus: wb_rst_i is asserted during a granted m1 access.
  - Required: all outputs go to 0 asynchronously; after release, m0 wins the next contention.

Source files
------------

// File: rtl/tjrpu_wb_arbiter.sv
// Two-master, one-slave Wishbone arbiter: round-robin grant held for a whole cyc,
// with forced termination of slave accesses that never ack.
module tjrpu_wb_arbiter #(
  parameter int unsigned TIMEOUT  = 255,
  parameter logic [31:0] ERR_DATA = 32'hDEAD_BEEF
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic        m0_cyc_i,
  input  logic        m0_stb_i,
  input  logic        m0_we_i,
  input  logic [3:0]  m0_sel_i,
  input  logic [31:0] m0_adr_i,
  input  logic [31:0] m0_dat_i,
  output logic        m0_ack_o,
  output logic [31:0] m0_dat_o,
  input  logic        m1_cyc_i,
  input  logic        m1_stb_i,
  input  logic        m1_we_i,
  input  logic [3:0]  m1_sel_i,
  input  logic [31:0] m1_adr_i,
  input  logic [31:0] m1_dat_i,
  output logic        m1_ack_o,
  output logic [31:0] m1_dat_o,
  output logic        s_cyc_o,
  output logic        s_stb_o,
  output logic        s_we_o,
  output logic [3:0]  s_sel_o,
  output logic [31:0] s_adr_o,
  output logic [31:0] s_dat_o,
  input  logic        s_ack_i,
  input  logic [31:0] s_dat_i,
  output logic        timeout_irq_o,
  output logic [7:0]  timeout_cnt_o
);

  typedef struct packed {
    logic        cyc;
    logic        stb;
    logic        we;
    logic [3:0]  sel;
    logic [31:0] adr;
    logic [31:0] dat;
  } wb_req_t;

  typedef enum logic [1:0] {IDLE, GNT0, GNT1} state_t;

  localparam logic [7:0] TMO = 8'(TIMEOUT);

  state_t     state, state_nxt, arb_state;
  logic       last;
  logic [7:0] tmo_q;
  logic [1:0] req;
  logic       granted, gsel, tmo_hit, ack_g;
  logic [31:0] dat_g;
  wb_req_t    m_req [2];
  wb_req_t    g_req;

  assign m_req[0] = '{cyc: m0_cyc_i, stb: m0_stb_i, we: m0_we_i, sel: m0_sel_i,
                      adr: m0_adr_i, dat: m0_dat_i};
  assign m_req[1] = '{cyc: m1_cyc_i, stb: m1_stb_i, we: m1_we_i, sel: m1_sel_i,
                      adr: m1_adr_i, dat: m1_dat_i};
  assign req     = {m1_cyc_i & m1_stb_i, m0_cyc_i & m0_stb_i};
  assign granted = (state != IDLE);
  assign gsel    = (state == GNT1);
  assign g_req   = m_req[gsel];

  // A slave ack in the same cycle always beats the timeout.
  assign tmo_hit = granted & g_req.stb & ~s_ack_i & (tmo_q == TMO);
  assign ack_g   = tmo_hit | (s_ack_i & g_req.stb);
  assign dat_g   = tmo_hit ? ERR_DATA : s_dat_i;

  // Round-robin choice; on release the releasing master's req is already low.
  always_comb begin
    arb_state = IDLE;
    if (req[0] && req[1]) arb_state = last ? GNT0 : GNT1;
    else if (req[0])      arb_state = GNT0;
    else if (req[1])      arb_state = GNT1;
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    state_nxt = arb_state;
      GNT0:    if (!m0_cyc_i) state_nxt = arb_state;
      GNT1:    if (!m1_cyc_i) state_nxt = arb_state;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    s_cyc_o  = 1'b0;
    s_stb_o  = 1'b0;
    s_we_o   = 1'b0;
    s_sel_o  = '0;
    s_adr_o  = '0;
    s_dat_o  = '0;
    m0_ack_o = 1'b0;
    m0_dat_o = '0;
    m1_ack_o = 1'b0;
    m1_dat_o = '0;
    if (granted) begin
      s_cyc_o = g_req.cyc & ~tmo_hit;
      s_stb_o = g_req.stb & ~tmo_hit;
      s_we_o  = g_req.we;
      s_sel_o = g_req.sel;
      s_adr_o = g_req.adr;
      s_dat_o = g_req.dat;
      if (gsel) begin
        m1_ack_o = ack_g;
        m1_dat_o = dat_g;
      end else begin
        m0_ack_o = ack_g;
        m0_dat_o = dat_g;
      end
    end
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      last          <= 1'b1;
      tmo_q         <= '0;
      timeout_irq_o <= 1'b0;
      timeout_cnt_o <= '0;
    end else begin
      if (state_nxt == GNT0 && state != GNT0) last <= 1'b0;
      if (state_nxt == GNT1 && state != GNT1) last <= 1'b1;
      if (state_nxt != state || !granted || !g_req.stb || s_ack_i || tmo_hit)
        tmo_q <= '0;
      else
        tmo_q <= tmo_q + 8'd1;
      timeout_irq_o <= tmo_hit;
      if (tmo_hit && timeout_cnt_o != 8'hFF) timeout_cnt_o <= timeout_cnt_o + 8'd1;
    end
  end

endmodule

// File: tb/tb_tjrpu_wb_arbiter.sv
// Directed bench for tjrpu_wb_arbiter with TIMEOUT=8; expected values are hand-derived.
module tb_tjrpu_wb_arbiter;

  logic        wb_clk_i = 1'b0;
  logic        wb_rst_i;
  logic        m0_cyc_i, m0_stb_i, m0_we_i;
  logic [3:0]  m0_sel_i;
  logic [31:0] m0_adr_i, m0_dat_i;
  logic        m0_ack_o;
  logic [31:0] m0_dat_o;
  logic        m1_cyc_i, m1_stb_i, m1_we_i;
  logic [3:0]  m1_sel_i;
  logic [31:0] m1_adr_i, m1_dat_i;
  logic        m1_ack_o;
  logic [31:0] m1_dat_o;
  logic        s_cyc_o, s_stb_o, s_we_o;
  logic [3:0]  s_sel_o;
  logic [31:0] s_adr_o, s_dat_o;
  logic        s_ack_i;
  logic [31:0] s_dat_i;
  logic        timeout_irq_o;
  logic [7:0]  timeout_cnt_o;

  int n_chk = 0;
  int n_err = 0;

  always #5 wb_clk_i = ~wb_clk_i;

  tjrpu_wb_arbiter #(.TIMEOUT(8), .ERR_DATA(32'hDEAD_BEEF)) dut (
    .wb_clk_i(wb_clk_i), .wb_rst_i(wb_rst_i),
    .m0_cyc_i(m0_cyc_i), .m0_stb_i(m0_stb_i), .m0_we_i(m0_we_i), .m0_sel_i(m0_sel_i),
    .m0_adr_i(m0_adr_i), .m0_dat_i(m0_dat_i), .m0_ack_o(m0_ack_o), .m0_dat_o(m0_dat_o),
    .m1_cyc_i(m1_cyc_i), .m1_stb_i(m1_stb_i), .m1_we_i(m1_we_i), .m1_sel_i(m1_sel_i),
    .m1_adr_i(m1_adr_i), .m1_dat_i(m1_dat_i), .m1_ack_o(m1_ack_o), .m1_dat_o(m1_dat_o),
    .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_we_o(s_we_o), .s_sel_o(s_sel_o),
    .s_adr_o(s_adr_o), .s_dat_o(s_dat_o), .s_ack_i(s_ack_i), .s_dat_i(s_dat_i),
    .timeout_irq_o(timeout_irq_o), .timeout_cnt_o(timeout_cnt_o)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h exp %h", tag, obs, exp);
    end
  endtask

  // Step to 1 time unit after the next rising edge; inputs change here.
  task automatic nxt();
    @(posedge wb_clk_i);
    #1;
  endtask

  task automatic drv(input int idx, input logic c, input logic s, input logic w,
                     input logic [31:0] a, input logic [31:0] d);
    if (idx == 0) begin
      m0_cyc_i = c; m0_stb_i = s; m0_we_i = w; m0_adr_i = a; m0_dat_i = d;
    end else begin
      m1_cyc_i = c; m1_stb_i = s; m1_we_i = w; m1_adr_i = a; m1_dat_i = d;
    end
  endtask

  task automatic do_reset();
    wb_rst_i = 1'b1;
    drv(0, 0, 0, 0, 0, 0);
    drv(1, 0, 0, 0, 0, 0);
    s_ack_i = 1'b0;
    s_dat_i = '0;
    repeat (2) @(posedge wb_clk_i);
    #1 wb_rst_i = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout exp finish");
    $fatal(1, "watchdog");
  end

  initial begin
    m0_sel_i = 4'hF;
    m1_sel_i = 4'hF;
    do_reset();
    #1;
    chk("rst_s_cyc", s_cyc_o, 0);
    chk("rst_s_adr", s_adr_o, 0);
    chk("rst_m0_ack", m0_ack_o, 0);
    chk("rst_m0_dat", m0_dat_o, 0);
    chk("rst_irq", timeout_irq_o, 0);
    chk("rst_tcnt", timeout_cnt_o, 0);

    // Single m0 read
    nxt(); drv(0, 1, 1, 0, 32'h3000_0004, 0); #1;
    chk("rd_idle_cyc", s_cyc_o, 0);
    nxt(); #1;
    chk("rd_gnt_cyc", s_cyc_o, 1);
    chk("rd_gnt_adr", s_adr_o, 32'h3000_0004);
    chk("rd_wait_ack", m0_ack_o, 0);
    nxt(); #1;
    chk("rd_wait2_ack", m0_ack_o, 0);
    nxt(); s_ack_i = 1; s_dat_i = 32'h1234_5678; #1;
    chk("rd_ack", m0_ack_o, 1);
    chk("rd_dat", m0_dat_o, 32'h1234_5678);
    chk("rd_m1_ack", m1_ack_o, 0);
    nxt(); s_ack_i = 0; drv(0, 0, 0, 0, 0, 0); #1;
    chk("rd_drop_cyc", s_cyc_o, 0);
    nxt(); drv(0, 1, 1, 0, 32'h3000_0008, 0); #1;
    chk("rd_back_idle", s_cyc_o, 0);
    nxt(); drv(0, 0, 0, 0, 0, 0);
    nxt();

    // Contention after reset
    do_reset();
    nxt(); drv(0, 1, 1, 0, 32'h100, 0); drv(1, 1, 1, 0, 32'h200, 0); #1;
    chk("ct_idle", s_cyc_o, 0);
    nxt(); s_ack_i = 1; s_dat_i = 32'hA5A5_0001; #1;
    chk("ct_first_adr", s_adr_o, 32'h100);
    chk("ct_m0_ack", m0_ack_o, 1);
    chk("ct_m1_ack", m1_ack_o, 0);
    chk("ct_m1_dat", m1_dat_o, 0);
    nxt(); s_ack_i = 0; drv(0, 0, 0, 0, 0, 0); #1;
    chk("ct_drop_cyc", s_cyc_o, 0);
    nxt(); #1;
    chk("ct_switch_cyc", s_cyc_o, 1);
    chk("ct_switch_adr", s_adr_o, 32'h200);
    nxt(); drv(1, 0, 0, 0, 0, 0);
    nxt(); drv(0, 1, 1, 0, 32'h110, 0);
    nxt(); #1;
    chk("ct_solo_adr", s_adr_o, 32'h110);
    nxt(); drv(0, 0, 0, 0, 0, 0);
    nxt(); drv(0, 1, 1, 0, 32'h120, 0); drv(1, 1, 1, 1, 32'h220, 0);
    nxt(); #1;
    chk("ct_rr_adr", s_adr_o, 32'h220);

    // Burst hold: m1 writes while m0 keeps requesting
    for (int b = 0; b < 4; b++) begin
      drv(1, 1, 1, 1, 32'h40 + 32'(4 * b), 32'hB000 + 32'(b));
      s_ack_i = 1;
      #1;
      chk("bu_adr", s_adr_o, 32'h40 + 32'(4 * b));
      chk("bu_dat", s_dat_o, 32'hB000 + 32'(b));
      chk("bu_m1_ack", m1_ack_o, 1);
      chk("bu_m0_ack", m0_ack_o, 0);
      nxt();
    end
    drv(1, 1, 0, 1, 32'h4C, 0); s_ack_i = 0; #1;
    chk("bu_gap_cyc", s_cyc_o, 1);
    chk("bu_gap_stb", s_stb_o, 0);
    nxt(); drv(1, 0, 0, 0, 0, 0); #1;
    chk("bu_drop_cyc", s_cyc_o, 0);
    nxt(); #1;
    chk("bu_m0_adr", s_adr_o, 32'h120);
    chk("bu_m0_cyc", s_cyc_o, 1);
    nxt(); drv(0, 0, 0, 0, 0, 0);
    nxt();

    // Ack in the 9th cycle wins over the timeout
    do_reset();
    nxt(); drv(0, 1, 1, 0, 32'h500, 0);
    for (int i = 1; i <= 8; i++) begin
      nxt(); #1;
      chk("ta_wait_ack", m0_ack_o, 0);
    end
    nxt(); s_ack_i = 1; s_dat_i = 32'hCAFE_F00D; #1;
    chk("ta_ack", m0_ack_o, 1);
    chk("ta_dat", m0_dat_o, 32'hCAFE_F00D);
    chk("ta_stb", s_stb_o, 1);
    nxt(); s_ack_i = 0; drv(0, 0, 0, 0, 0, 0); #1;
    chk("ta_irq", timeout_irq_o, 0);
    chk("ta_tcnt", timeout_cnt_o, 0);

    // Timeout on the 9th stb cycle
    nxt(); drv(0, 1, 1, 0, 32'h504, 0);
    for (int i = 1; i <= 8; i++) begin
      nxt(); #1;
      chk("to_wait_ack", m0_ack_o, 0);
      chk("to_wait_stb", s_stb_o, 1);
    end
    nxt(); #1;
    chk("to_ack", m0_ack_o, 1);
    chk("to_dat", m0_dat_o, 32'hDEAD_BEEF);
    chk("to_s_stb", s_stb_o, 0);
    chk("to_s_cyc", s_cyc_o, 0);
    chk("to_irq_early", timeout_irq_o, 0);
    nxt(); drv(0, 0, 0, 0, 0, 0); #1;
    chk("to_irq", timeout_irq_o, 1);
    chk("to_tcnt", timeout_cnt_o, 1);
    nxt(); #1;
    chk("to_irq_off", timeout_irq_o, 0);
    chk("to_tcnt_hold", timeout_cnt_o, 1);

    // Abort: m0 drops cyc while waiting
    nxt(); drv(0, 1, 1, 0, 32'h600, 0);
    nxt(); #1;
    chk("ab_cyc_on", s_cyc_o, 1);
    nxt(); m0_cyc_i = 0; #1;
    chk("ab_cyc_off", s_cyc_o, 0);
    chk("ab_ack", m0_ack_o, 0);
    nxt(); drv(0, 0, 0, 0, 0, 0);
    nxt();

    // Reset in the middle of a granted m1 access
    nxt(); drv(1, 1, 1, 1, 32'h700, 32'h77);
    nxt(); s_ack_i = 1; s_dat_i = 32'h5555_AAAA; #1;
    chk("rs_m1_ack", m1_ack_o, 1);
    #2 wb_rst_i = 1;
    #1;
    chk("rs_s_cyc", s_cyc_o, 0);
    chk("rs_s_adr", s_adr_o, 0);
    chk("rs_m1_ack0", m1_ack_o, 0);
    chk("rs_m1_dat0", m1_dat_o, 0);
    chk("rs_tcnt", timeout_cnt_o, 0);
    s_ack_i = 0;
    nxt(); wb_rst_i = 0; drv(0, 1, 1, 0, 32'h800, 0);
    nxt(); #1;
    chk("rs_m0_wins", s_adr_o, 32'h800);
    nxt(); drv(0, 0, 0, 0, 0, 0); drv(1, 0, 0, 0, 0, 0);
    nxt();

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
